// File: rtl/avalon_pkt_arbiter.sv
// Packet-atomic round-robin N-to-1 Avalon-ST arbiter with one registered output stage.
// Packets longer than MAX_PKT_LEN are cut with a forced eop and their tail beats are dropped.
module avalon_pkt_arbiter #(
  parameter int DWIDTH      = 4,
  parameter int N_SNK       = 2,
  parameter int MAX_PKT_LEN = 5
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic [N_SNK-1:0][DWIDTH-1:0]  snk_data_i,
  input  logic [N_SNK-1:0]              snk_valid_i,
  input  logic [N_SNK-1:0]              snk_startofpacket_i,
  input  logic [N_SNK-1:0]              snk_endofpacket_i,
  output logic [N_SNK-1:0]              snk_ready_o,
  output logic [DWIDTH-1:0]             src_data_o,
  output logic                          src_valid_o,
  output logic                          src_startofpacket_o,
  output logic                          src_endofpacket_o,
  input  logic                          src_ready_i,
  output logic [N_SNK-1:0]              grant_o,
  output logic                          trunc_o
);

  localparam int PW = (N_SNK > 1) ? $clog2(N_SNK) : 1;
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gidx;
  logic [CW-1:0]   beat_cnt;

  logic            out_free;
  logic [PW-1:0]   pick;
  logic            found;
  int              idx_c;
  logic            sel_vld;
  logic            sel_eop;
  logic [DWIDTH-1:0] sel_dat;
  logic            cur_last;
  logic            acc_x;
  logic            acc_d;
  logic [PW-1:0]   nxt_ptr;

  assign out_free = !src_valid_o || src_ready_i;
  assign sel_vld  = snk_valid_i[gidx];
  assign sel_eop  = snk_endofpacket_i[gidx];
  assign sel_dat  = snk_data_i[gidx];
  assign cur_last = (beat_cnt == CW'(MAX_PKT_LEN - 1));
  assign acc_x    = (state == XFER) && sel_vld && out_free;
  assign acc_d    = (state == DROP) && sel_vld;
  assign nxt_ptr  = (gidx == PW'(N_SNK - 1)) ? '0 : gidx + PW'(1);

  // Round-robin search starting at rr_ptr, wrapping modulo N_SNK.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx_c = 0;
    for (int i = 0; i < N_SNK; i++) begin
      idx_c = (int'(rr_ptr) + i) % N_SNK;
      if (!found && snk_valid_i[idx_c] && snk_startofpacket_i[idx_c]) begin
        found = 1'b1;
        pick  = PW'(idx_c);
      end
    end
  end

  // Orphan beats are swallowed in IDLE; readiness is forced low while reset is held.
  always_comb begin
    snk_ready_o = '0;
    case (state)
      IDLE:    snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
      XFER:    snk_ready_o[gidx] = out_free;
      DROP:    snk_ready_o[gidx] = 1'b1;
      default: snk_ready_o = '0;
    endcase
    if (!arst_n_i) snk_ready_o = '0;
  end

  always_comb begin
    grant_o = '0;
    if (state != IDLE) grant_o[gidx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      gidx                <= '0;
      beat_cnt            <= '0;
      src_valid_o         <= 1'b0;
      src_data_o          <= '0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      trunc_o             <= 1'b0;
    end else begin
      trunc_o <= 1'b0;

      if (out_free) begin
        src_valid_o <= acc_x;
        if (acc_x) begin
          src_data_o          <= sel_dat;
          src_startofpacket_o <= (beat_cnt == '0);
          src_endofpacket_o   <= sel_eop || cur_last;
        end
      end

      case (state)
        IDLE: begin
          if (found) begin
            gidx     <= pick;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (acc_x) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (sel_eop) begin
              state  <= IDLE;
              rr_ptr <= nxt_ptr;
            end else if (cur_last) begin
              trunc_o <= 1'b1;
              state   <= DROP;
            end
          end
        end
        DROP: begin
          if (acc_d && sel_eop) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_pkt_arbiter.sv
// Randomised bench for avalon_pkt_arbiter against a packet-level round-robin/truncation model.
module tb_avalon_pkt_arbiter;

  localparam int DW   = 4;
  localparam int NS   = 2;
  localparam int MAXL = 5;

  logic                    clk_i = 1'b0;
  logic                    arst_n_i;
  logic [NS-1:0][DW-1:0]   snk_data_i;
  logic [NS-1:0]           snk_valid_i;
  logic [NS-1:0]           snk_startofpacket_i;
  logic [NS-1:0]           snk_endofpacket_i;
  logic [NS-1:0]           snk_ready_o;
  logic [DW-1:0]           src_data_o;
  logic                    src_valid_o;
  logic                    src_startofpacket_o;
  logic                    src_endofpacket_o;
  logic                    src_ready_i;
  logic [NS-1:0]           grant_o;
  logic                    trunc_o;

  avalon_pkt_arbiter #(.DWIDTH(DW), .N_SNK(NS), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i),
    .snk_startofpacket_i(snk_startofpacket_i), .snk_endofpacket_i(snk_endofpacket_i),
    .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o), .src_valid_o(src_valid_o),
    .src_startofpacket_o(src_startofpacket_o), .src_endofpacket_o(src_endofpacket_o),
    .src_ready_i(src_ready_i), .grant_o(grant_o), .trunc_o(trunc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] d;
    bit            sop;
    bit            eop;
    bit            orph;
    int            idx;
  } beat_t;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] d;
  } obeat_t;

  beat_t         in_q[NS][$];
  int            mdl_len[NS][$];
  logic [DW-1:0] mdl_dat[NS][$];
  obeat_t        exp_q[$];
  int            mdl_ptr;
  int            exp_trunc;
  int            trunc_cnt;
  bit            presented[NS];
  bit            gaps;
  int            rdy_mode;
  bit            fwd_prev;
  logic [DW-1:0] fwd_prev_d;
  int            checks = 0;
  int            errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input int k, input logic [DW-1:0] d, input bit sop, input bit eop, input int idx);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop; b.orph = 1'b0; b.idx = idx;
    in_q[k].push_back(b);
    mdl_dat[k].push_back(d);
  endtask

  task automatic add_pkt(input int k, input int len);
    for (int i = 0; i < len; i++)
      add_beat(k, DW'($urandom), i == 0, i == len - 1, i);
    mdl_len[k].push_back(len);
  endtask

  task automatic add_orphan(input int k);
    beat_t b;
    b.d = DW'($urandom); b.sop = 1'b0; b.eop = 1'b0; b.orph = 1'b1; b.idx = 0;
    in_q[k].push_back(b);
  endtask

  // Whole packets leave in round-robin order among inputs holding pending packets,
  // each cut to MAXL beats with the last kept beat marked eop.
  task automatic build_model();
    int k, c, len;
    obeat_t o;
    forever begin
      k = -1;
      for (int i = 0; i < NS; i++) begin
        c = (mdl_ptr + i) % NS;
        if (k < 0 && mdl_len[c].size() > 0) k = c;
      end
      if (k < 0) break;
      len = mdl_len[k].pop_front();
      for (int i = 0; i < len; i++) begin
        o.d   = mdl_dat[k].pop_front();
        o.sop = (i == 0);
        o.eop = (i == len - 1) || (i == MAXL - 1);
        if (i < MAXL) exp_q.push_back(o);
      end
      if (len > MAXL) exp_trunc++;
      mdl_ptr = (k + 1) % NS;
    end
  endtask

  task automatic cycle();
    beat_t  b;
    bit     stall;
    obeat_t o;
    @(negedge clk_i);
    for (int k = 0; k < NS; k++) begin
      if (in_q[k].size() > 0) begin
        b = in_q[k][0];
        if (!presented[k] && gaps && !b.sop && !b.orph && $urandom_range(0, 2) == 0) begin
          snk_valid_i[k] = 1'b0;
        end else begin
          presented[k]           = 1'b1;
          snk_valid_i[k]         = 1'b1;
          snk_data_i[k]          = b.d;
          snk_startofpacket_i[k] = b.sop;
          snk_endofpacket_i[k]   = b.eop;
        end
      end else begin
        snk_valid_i[k]         = 1'b0;
        snk_startofpacket_i[k] = 1'b0;
        snk_endofpacket_i[k]   = 1'b0;
      end
    end
    case (rdy_mode)
      0:       src_ready_i = 1'b1;
      1:       src_ready_i = 1'($urandom_range(0, 1));
      default: src_ready_i = !src_ready_i;
    endcase
    #4;
    if (fwd_prev) begin
      check_val("lat_vld", 32'(src_valid_o), 32'd1);
      check_val("lat_dat", 32'(src_data_o), 32'(fwd_prev_d));
    end
    fwd_prev = 1'b0;
    stall = src_valid_o && !src_ready_i;
    for (int k = 0; k < NS; k++) begin
      if (in_q[k].size() > 0 && snk_valid_i[k]) begin
        b = in_q[k][0];
        if (stall && !b.orph && b.idx < MAXL)
          check_val("stall_rdy", 32'(snk_ready_o[k]), 32'd0);
        if (snk_ready_o[k]) begin
          if (b.orph) check_val("orph_gnt", 32'(grant_o), 32'd0);
          else        check_val("gnt", 32'(grant_o), 32'(1 << k));
          if (!b.orph && b.idx < MAXL) begin
            fwd_prev   = 1'b1;
            fwd_prev_d = b.d;
          end
          void'(in_q[k].pop_front());
          presented[k] = 1'b0;
        end
      end
    end
    if (src_valid_o && src_ready_i) begin
      if (exp_q.size() == 0) begin
        check_val("extra_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        o = exp_q.pop_front();
        check_val("beat", 32'({src_startofpacket_o, src_endofpacket_o, src_data_o}), 32'(o));
      end
    end
    if (trunc_o) begin
      trunc_cnt++;
      check_val("trunc_eop", 32'(src_valid_o && src_endofpacket_o), 32'd1);
    end
  endtask

  task automatic run_drain(input int max_cyc);
    int left;
    trunc_cnt = 0;
    exp_trunc = 0;
    build_model();
    for (int n = 0; n < max_cyc; n++) begin
      cycle();
      if (in_q[0].size() == 0 && in_q[1].size() == 0 && exp_q.size() == 0 && !src_valid_o) break;
    end
    left = in_q[0].size() + in_q[1].size() + exp_q.size();
    check_val("drain", 32'(left), 32'd0);
    check_val("trunc_cnt", 32'(trunc_cnt), 32'(exp_trunc));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_vld"}, 32'(src_valid_o), 32'd0);
    check_val({tag, "_sop"}, 32'(src_startofpacket_o), 32'd0);
    check_val({tag, "_eop"}, 32'(src_endofpacket_o), 32'd0);
    check_val({tag, "_dat"}, 32'(src_data_o), 32'd0);
    check_val({tag, "_rdy"}, 32'(snk_ready_o), 32'd0);
    check_val({tag, "_gnt"}, 32'(grant_o), 32'd0);
    check_val({tag, "_trc"}, 32'(trunc_o), 32'd0);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < NS; k++) begin
      in_q[k].delete();
      mdl_len[k].delete();
      mdl_dat[k].delete();
      presented[k] = 1'b0;
    end
    exp_q.delete();
    fwd_prev            = 1'b0;
    snk_valid_i         = '0;
    snk_startofpacket_i = '0;
    snk_endofpacket_i   = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    arst_n_i    = 1'b0;
    snk_data_i  = '0;
    src_ready_i = 1'b1;
    gaps        = 1'b0;
    rdy_mode    = 0;
    mdl_ptr     = 0;
    clear_stim();
    #12;
    check_reset_outputs("rst");
    @(negedge clk_i);
    arst_n_i = 1'b1;

    // Single 3-beat packet on input 0 with fixed data.
    add_beat(0, 4'd7, 1'b1, 1'b0, 0);
    add_beat(0, 4'd2, 1'b0, 1'b0, 1);
    add_beat(0, 4'd9, 1'b0, 1'b1, 2);
    mdl_len[0].push_back(3);
    run_drain(50);

    // Both inputs contend every arbitration; order must alternate.
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, $urandom_range(1, 4));
      add_pkt(1, $urandom_range(1, 4));
    end
    run_drain(200);

    // Over-length, exact-length and short packets on input 1.
    add_pkt(1, 7);
    add_pkt(1, MAXL);
    add_pkt(1, 2);
    run_drain(100);

    // Output stalled every other cycle during a full-length packet.
    rdy_mode = 2;
    add_pkt(0, MAXL);
    run_drain(100);
    rdy_mode = 0;

    // Orphan beat ahead of a real packet.
    add_orphan(0);
    add_pkt(0, 3);
    run_drain(50);

    // Random lengths, random backpressure, mid-packet valid gaps.
    gaps     = 1'b1;
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) add_pkt($urandom_range(0, 1), $urandom_range(1, 8));
    run_drain(3000);

    // Reset in the middle of a packet, then input 0 must win first.
    gaps     = 1'b0;
    rdy_mode = 0;
    add_pkt(0, MAXL);
    add_pkt(1, 3);
    build_model();
    repeat (4) cycle();
    #3;
    arst_n_i = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    clear_stim();
    mdl_ptr = 0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    add_pkt(1, 3);
    add_pkt(0, 2);
    run_drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_pkt_arbiter.md
# avalon_pkt_arbiter

Packet-atomic N-to-1 Avalon-ST arbiter sitting in front of the `sort_avalon` packet sorter. It grants whole packets from N_SNK upstream sources round-robin and forwards them through a single registered output stage. It also enforces the sorter's MAX_PKT_LEN buffer depth:

- Over-length packets are truncated with a forced endofpacket.
- Their remaining input beats are discarded.

## Interface

- DWIDTH, 4: data width per beat.
- N_SNK, 2: number of upstream sink ports (≥2).
- MAX_PKT_LEN, 5: max beats forwarded per packet; must equal the downstream sorter's MAX_PKT_LEN.

Ports:

- clk_i  in  1  single clock.
- arst_n_i  in  1  reset, asynchronous, active-low.
- snk_data_i  in  [N_SNK-1:0][DWIDTH-1:0]  per-input beat data.
- snk_valid_i  in  N_SNK  per-input valid.
- snk_startofpacket_i  in  N_SNK  per-input sop.
- snk_endofpacket_i  in  N_SNK  per-input eop.
- snk_ready_o  out  N_SNK  per-input ready.
- src_data_o  out  DWIDTH  output beat data.
- src_valid_o  out  1  output valid.
- src_startofpacket_o  out  1  output sop.
- src_endofpacket_o  out  1  output eop.
- src_ready_i  in  1  downstream ready.
- grant_o  out  N_SNK  one-hot current grant; 0 when idle.
- trunc_o  out  1  one-cycle pulse when a packet is truncated.

## Operation

- FSM states: IDLE, XFER, DROP.
- IDLE:
  - A request is snk_valid_i[k] && snk_startofpacket_i[k].
  - Pick the first requester searching from rr_ptr upward, wrapping modulo N_SNK.
  - Load grant and clear beat_cnt; go to XFER.
  - Orphan beats (valid without sop) on any input: snk_ready_o[k]=1, beat discarded, never forwarded.
- XFER:
  - snk_ready_o[g] = out_free, where out_free = !src_valid_o || src_ready_i; all other readies are 0.
  - Accepted beat (valid && ready): register data into the output stage.
  - Output sop = (beat_cnt==0). A sop seen mid-packet is ignored and the beat is forwarded as data.
  - Output eop = input eop || (beat_cnt==MAX_PKT_LEN-1).
  - beat_cnt is $clog2(MAX_PKT_LEN+1) bits wide and increments per accepted beat.
  - Accepted beat with input eop: go to IDLE, rr_ptr <= g+1 (mod N_SNK).
  - Accepted beat at beat_cnt==MAX_PKT_LEN-1 without input eop: forced eop, trunc_o=1 for that cycle, go to DROP.
- DROP:
  - snk_ready_o[g]=1; beats are discarded.
  - On accepted input eop: go to IDLE, rr_ptr <= g+1.
  - The output stage still drains independently.
- Output stage: one register.
  - Loads when out_free.
  - src_valid_o <= accepted beat in XFER.
  - Data, sop and eop hold while src_valid_o && !src_ready_i.
- grant_o = grant register while in XFER or DROP; 0 in IDLE.

## Timing

- Reset (arst_n_i low, asynchronous):
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - src_valid_o, src_startofpacket_o, src_endofpacket_o = 0; src_data_o = 0.
  - snk_ready_o=0, grant_o=0, trunc_o=0.
  - Applies immediately, also mid-packet; the partial packet is lost.
  - Deassertion is synchronised externally.
- Arbitration latency: request seen in IDLE at cycle t → XFER at t+1, with snk_ready_o[g] high at t+1 if out_free.
- Datapath latency: beat accepted at cycle t appears on src_* at t+1.
- Back-to-back packets: eop accepted at t → IDLE at t+1 → next grant XFER at t+2. This gives one idle bubble per packet.
- Full throughput within a packet when src_ready_i is held high: one beat per cycle.
- Backpressure: src_ready_i low with src_valid_o high forces snk_ready_o low combinationally. No beat is lost or duplicated.
- Simultaneous events:
  - Packet of exactly MAX_PKT_LEN beats with eop on the last beat: no truncation, trunc_o stays 0, go directly to IDLE.
  - Single-beat packet (sop&eop): src sop=eop=1 on the same beat.

## Test plan

- Reset, then input0 sends 3-beat packet 7,2,9 with src_ready_i=1 → src beats 7,2,9 one cycle after each acceptance; sop on 7, eop on 9; grant_o=01 during transfer.
- Both inputs request sop in the same cycle, repeatedly → grants alternate 0,1,0,1; each packet forwarded contiguously, never interleaved.
- Input1 sends 7-beat packet with MAX_PKT_LEN=5 → 5 beats forwarded, eop forced on beat 5, trunc_o pulses once; beats 6-7 discarded with snk_ready_o[1]=1; next packet starts clean.
- Toggle src_ready_i low every other cycle during a 5-beat packet → output sequence identical, no drops or duplicates, snk_ready_o low whenever the output is stalled.
- Orphan beat (valid, no sop) on input0 in IDLE → discarded with ready=1, nothing on src; a following sop packet forwards normally.
- Assert arst_n_i low mid-packet → all outputs 0 immediately; after release, input0 has priority and a new packet forwards correctly.
